uart_tx_arbiter: RTL

Shares one `uart_tx` byte port among `NUM_REQ` byte-stream requesters, for example a debug console, a status reporter and a trace dumper. Arbitration is round-robin. A grant is held for a whole packet, until the byte marked `last` is accepted or a burst limit is reached. The block sits directly upstream of `uart_tx`: `tx_valid` and `tx_data` drive its `data_write_valid` and `data_in`, and its `data_write_ready` returns as `tx_ready`.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The HDR state is always declared; it is reachable only when UART_TX_ARBITER_HDR_EN is defined.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   localparam logic [3:0] ARB_HDR_TAG = 4'hA;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NUM_REQ.
// Works for non-power-of-2 NUM_REQ by using explicit modular addition instead of bit rotation.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      idx
);

   logic [NUM_REQ-1:0] w_rot;
   logic [IW-1:0]      w_k;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
      logic [IW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IW+1)'(NUM_REQ)) begin
         s = s - (IW+1)'(NUM_REQ);
      end else begin
         s = s;
      end
      return s[IW-1:0];
   endfunction

   // rotate requests so that position 0 corresponds to ptr
   always_comb begin
      w_rot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_rot[k] = req[wrap_add(ptr, IW'(k))];
      end
   end

   // lowest rotated index wins: scan downward so the last hit is the smallest
   always_comb begin
      w_k = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_k = w_rot[k] ? IW'(k) : w_k;
      end
      found = |w_rot;
      idx   = wrap_add(ptr, w_k);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte port among NUM_REQ packet streams.
// Optional per-grant header byte enabled by defining UART_TX_ARBITER_HDR_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                         clk,
   input  logic                         areset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*8-1:0]         req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         tx_valid,
   output logic [7:0]                   tx_data,
   input  logic                         tx_ready,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy
);

   localparam int IW  = $clog2(NUM_REQ);
   localparam int BCW = $clog2(MAX_BURST + 1);

   arb_state_t     r_state;
   arb_state_t     w_state_nxt;
   logic [IW-1:0]  r_grant;
   logic [IW-1:0]  w_grant_nxt;
   logic [IW-1:0]  r_rr_ptr;
   logic [IW-1:0]  w_rr_ptr_nxt;
   logic [BCW-1:0] r_burst_cnt;
   logic [BCW-1:0] w_burst_cnt_nxt;
   logic           r_busy;
   logic           w_found;
   logic [IW-1:0]  w_idx;
   logic [IW-1:0]  w_grant_inc;
   logic           w_xfer;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (r_rr_ptr),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_grant_inc = (r_grant == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : (r_grant + IW'(1));
   assign w_xfer      = tx_valid && tx_ready;
   assign grant_id    = r_grant;
   assign busy        = r_busy;

   // next-state, counter updates and the combinational DATA-path mux
   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_burst_cnt_nxt = r_burst_cnt;
      tx_valid        = 1'b0;
      tx_data         = 8'h00;
      req_ready       = '0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_grant_nxt     = w_idx;
               w_burst_cnt_nxt = '0;
`ifdef UART_TX_ARBITER_HDR_EN
               w_state_nxt     = HDR;
`else
               w_state_nxt     = DATA;
`endif
            end else begin
               w_state_nxt     = IDLE;
            end
         end
         HDR: begin
`ifdef UART_TX_ARBITER_HDR_EN
            tx_valid = 1'b1;
            tx_data  = {ARB_HDR_TAG, 4'(r_grant)};
            if (tx_ready) begin
               w_state_nxt = DATA;
            end else begin
               w_state_nxt = HDR;
            end
`else
            w_state_nxt = IDLE;
`endif
         end
         DATA: begin
            tx_valid           = req_valid[r_grant];
            tx_data            = req_data[{r_grant, 3'b000} +: 8];
            req_ready[r_grant] = tx_ready;
            if (w_xfer) begin
               w_burst_cnt_nxt = r_burst_cnt + BCW'(1);
               // packet end and burst limit on the same byte release only once
               if (req_last[r_grant] || (r_burst_cnt == BCW'(MAX_BURST - 1))) begin
                  w_state_nxt  = IDLE;
                  w_rr_ptr_nxt = w_grant_inc;
               end else begin
                  w_state_nxt  = DATA;
               end
            end else begin
               w_state_nxt = DATA;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // state, grant, pointer and counter registers; busy decoded from next state
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

endmodule
